// File: rtl/bp_me_mem_arb_2to1.sv
// Two-client arbiter in front of a single BedRock memory port.
// Commands are granted round-robin with zero latency. The source of each
// accepted command is remembered in an in-order tracker, and each memory
// response is routed back to the client that issued the oldest command.
module bp_me_mem_arb_2to1
  #(parameter int msg_width_p       = 128
   ,parameter int max_outstanding_p = 4
   )
   (input  logic                                     clk_i
   ,input  logic                                     reset_n_i
   ,input  logic                                     drain_i

   ,input  logic [msg_width_p-1:0]                   cmd0_i
   ,input  logic                                     cmd0_v_i
   ,output logic                                     cmd0_yumi_o
   ,input  logic [msg_width_p-1:0]                   cmd1_i
   ,input  logic                                     cmd1_v_i
   ,output logic                                     cmd1_yumi_o

   ,output logic [msg_width_p-1:0]                   resp0_o
   ,output logic                                     resp0_v_o
   ,input  logic                                     resp0_yumi_i
   ,output logic [msg_width_p-1:0]                   resp1_o
   ,output logic                                     resp1_v_o
   ,input  logic                                     resp1_yumi_i

   ,output logic [msg_width_p-1:0]                   mem_cmd_o
   ,output logic                                     mem_cmd_v_o
   ,input  logic                                     mem_cmd_ready_and_i
   ,input  logic [msg_width_p-1:0]                   mem_resp_i
   ,input  logic                                     mem_resp_v_i
   ,output logic                                     mem_resp_yumi_o

   ,output logic [$clog2(max_outstanding_p+1)-1:0]   outstanding_o
   ,output logic                                     idle_o
   ,output logic                                     error_o
   );

   localparam int ptr_w_lp = $clog2(max_outstanding_p);
   localparam int cnt_w_lp = $clog2(max_outstanding_p+1);
   localparam logic [cnt_w_lp-1:0] max_cnt_lp = cnt_w_lp'(max_outstanding_p);

   logic                         last_grant_r;
   logic [max_outstanding_p-1:0] src_r;
   logic [ptr_w_lp-1:0]          wptr_r, rptr_r;
   logic [cnt_w_lp-1:0]          count_r;
   logic                         error_r;

   logic gnt1, can_issue, cmd_hs, have_head, head, pop, err_set;

   // Round-robin grant, zero-latency command mux and handshake decode.
   // The full check uses only the registered count so the grant never
   // depends on the response-side yumi in the same cycle.
   always_comb begin
      gnt1        = cmd1_v_i & (~cmd0_v_i | ~last_grant_r);
      can_issue   = reset_n_i & ~drain_i & (count_r < max_cnt_lp);
      mem_cmd_v_o = can_issue & (cmd0_v_i | cmd1_v_i);
      mem_cmd_o   = gnt1 ? cmd1_i : cmd0_i;
      cmd_hs      = mem_cmd_v_o & mem_cmd_ready_and_i;
      cmd0_yumi_o = cmd_hs & ~gnt1;
      cmd1_yumi_o = cmd_hs &  gnt1;
   end

   // Response routing by the tracker head, plus protocol error detection.
   always_comb begin
      have_head       = (count_r != '0);
      head            = src_r[rptr_r];
      resp0_o         = mem_resp_i;
      resp1_o         = mem_resp_i;
      resp0_v_o       = reset_n_i & mem_resp_v_i & have_head & ~head;
      resp1_v_o       = reset_n_i & mem_resp_v_i & have_head &  head;
      mem_resp_yumi_o = head ? (resp1_yumi_i & resp1_v_o) : (resp0_yumi_i & resp0_v_o);
      pop             = mem_resp_yumi_o;
      err_set         = (mem_resp_v_i & ~have_head)
                      | (resp0_yumi_i & ~resp0_v_o)
                      | (resp1_yumi_i & ~resp1_v_o);
      outstanding_o   = count_r;
      idle_o          = ~have_head & ~mem_cmd_v_o;
      error_o         = error_r;
   end

   // Tracker storage: one source bit per accepted command, written at the tail.
   always_ff @(posedge clk_i) begin
      if (cmd_hs)
         src_r[wptr_r] <= gnt1;
   end

   // Grant history, tracker pointers/occupancy and the sticky error flag.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         last_grant_r <= 1'b1;
         wptr_r       <= '0;
         rptr_r       <= '0;
         count_r      <= '0;
         error_r      <= 1'b0;
      end else begin
         if (cmd_hs) begin
            last_grant_r <= gnt1;
            wptr_r       <= wptr_r + ptr_w_lp'(1);
         end
         if (pop)
            rptr_r <= rptr_r + ptr_w_lp'(1);
         case ({cmd_hs, pop})
            2'b10:   count_r <= count_r + cnt_w_lp'(1);
            2'b01:   count_r <= count_r - cnt_w_lp'(1);
            default: count_r <= count_r;
         endcase
         if (err_set)
            error_r <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bp_me_mem_arb_2to1.sv
// Randomized scoreboard bench for the 2:1 memory arbiter.
// The client and memory models live in one driver process; an independent
// monitor compares the DUT against a queue-based reference of the arbiter rules.
module tb_bp_me_mem_arb_2to1;
   localparam int W  = 128;
   localparam int MO = 4;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic          reset_n_i, drain_i;
   logic [W-1:0]  cmd0_i, cmd1_i, resp0_o, resp1_o, mem_cmd_o, mem_resp_i;
   logic          cmd0_v_i, cmd0_yumi_o, cmd1_v_i, cmd1_yumi_o;
   logic          resp0_v_o, resp0_yumi_i, resp1_v_o, resp1_yumi_i;
   logic          mem_cmd_v_o, mem_cmd_ready_and_i, mem_resp_v_i, mem_resp_yumi_o;
   logic [2:0]    outstanding_o;
   logic          idle_o, error_o;

   bp_me_mem_arb_2to1 #(.msg_width_p(W), .max_outstanding_p(MO)) dut
     (.clk_i(clk_i), .reset_n_i(reset_n_i), .drain_i(drain_i)
     ,.cmd0_i(cmd0_i), .cmd0_v_i(cmd0_v_i), .cmd0_yumi_o(cmd0_yumi_o)
     ,.cmd1_i(cmd1_i), .cmd1_v_i(cmd1_v_i), .cmd1_yumi_o(cmd1_yumi_o)
     ,.resp0_o(resp0_o), .resp0_v_o(resp0_v_o), .resp0_yumi_i(resp0_yumi_i)
     ,.resp1_o(resp1_o), .resp1_v_o(resp1_v_o), .resp1_yumi_i(resp1_yumi_i)
     ,.mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_and_i(mem_cmd_ready_and_i)
     ,.mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_yumi_o(mem_resp_yumi_o)
     ,.outstanding_o(outstanding_o), .idle_o(idle_o), .error_o(error_o));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // control knobs, written by the sequence on posedges
   bit rst_req = 1'b1, drain_c = 1'b0, hold_resp = 1'b0, rand_ready = 1'b0;
   bit rand_yumi = 1'b0, block_y1 = 1'b0, spurious = 1'b0;
   int release_cnt = 0, resp_delay = 1, seq = 0;

   // client and memory model state
   logic [W-1:0] c0_q[$], c1_q[$], exp0[$], exp1[$], mq_d[$];
   int           mq_t[$];
   int           cyc = 0;
   bit           cap_c0, cap_c1, cap_mcmd, cap_mr;
   logic [W-1:0] cap_cmd;

   // monitor statistics
   int peak, r0_cnt, r1_cnt, hs_cnt;
   bit gseq[$];

   // A new client command; memory answers with the bitwise inverse.
   task automatic push_cmd(input bit c);
      logic [W-1:0] m;
      m = {c, seq[30:0], $urandom, $urandom, $urandom};
      seq++;
      if (c) begin c1_q.push_back(m); exp1.push_back(~m); end
      else   begin c0_q.push_back(m); exp0.push_back(~m); end
   endtask

   // Driver: clients, memory model and reset, all driven just after negedge.
   initial begin
      cap_c0 = 0; cap_c1 = 0; cap_mcmd = 0; cap_mr = 0; cap_cmd = '0;
      reset_n_i = 0; drain_i = 0; cmd0_i = '0; cmd1_i = '0; cmd0_v_i = 0; cmd1_v_i = 0;
      resp0_yumi_i = 0; resp1_yumi_i = 0; mem_cmd_ready_and_i = 0;
      mem_resp_i = '0; mem_resp_v_i = 0;
      forever begin
         @(negedge clk_i);
         cyc++;
         if (cap_c0 && c0_q.size() > 0) void'(c0_q.pop_front());
         if (cap_c1 && c1_q.size() > 0) void'(c1_q.pop_front());
         if (cap_mr && mq_d.size() > 0) begin
            void'(mq_d.pop_front()); void'(mq_t.pop_front());
            if (release_cnt > 0) release_cnt--;
         end
         if (cap_mcmd) begin mq_d.push_back(cap_cmd); mq_t.push_back(cyc); end
         if (rst_req) begin
            c0_q.delete(); c1_q.delete(); exp0.delete(); exp1.delete();
            mq_d.delete(); mq_t.delete();
         end
         reset_n_i = !rst_req;
         drain_i   = drain_c;
         cmd0_v_i  = (c0_q.size() > 0);
         cmd0_i    = cmd0_v_i ? c0_q[0] : '0;
         cmd1_v_i  = (c1_q.size() > 0);
         cmd1_i    = cmd1_v_i ? c1_q[0] : '0;
         mem_cmd_ready_and_i = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
         mem_resp_v_i = 1'b0;
         mem_resp_i   = '0;
         if (spurious) begin
            mem_resp_v_i = 1'b1;
            mem_resp_i   = {$urandom, $urandom, $urandom, $urandom};
         end else if (mq_d.size() > 0 && (cyc - mq_t[0]) >= resp_delay
                      && (!hold_resp || release_cnt > 0)) begin
            mem_resp_v_i = 1'b1;
            mem_resp_i   = ~mq_d[0];
         end
         resp0_yumi_i = 1'b0;
         resp1_yumi_i = 1'b0;
         #1;
         resp0_yumi_i = resp0_v_o && (!rand_yumi || $urandom_range(3) != 0);
         resp1_yumi_i = resp1_v_o && !block_y1 && (!rand_yumi || $urandom_range(3) != 0);
         #1;
         cap_c0   = cmd0_yumi_o;
         cap_c1   = cmd1_yumi_o;
         cap_mcmd = mem_cmd_v_o && mem_cmd_ready_and_i;
         cap_cmd  = mem_cmd_o;
         cap_mr   = mem_resp_yumi_o;
      end
   end

   // Monitor: reference model of the arbitration rules plus response scoreboard.
   initial begin
      bit m_prev, m_err, c0v, c1v, eg, ev, hs, have, head, e0, e1, ey;
      bit m_src[$];
      m_prev = 1; m_err = 0;
      forever begin
         @(negedge clk_i);
         #3;
         if (!reset_n_i) begin
            chk("rst_outputs_low", {mem_cmd_v_o, cmd0_yumi_o, cmd1_yumi_o,
                                    resp0_v_o, resp1_v_o, mem_resp_yumi_o}, '0);
            m_src.delete(); m_prev = 1; m_err = 0;
         end else begin
            c0v  = cmd0_v_i; c1v = cmd1_v_i;
            eg   = (c0v && c1v) ? !m_prev : c1v;
            ev   = (c0v || c1v) && !drain_i && (m_src.size() < MO);
            hs   = ev && mem_cmd_ready_and_i;
            have = (m_src.size() > 0);
            head = have ? m_src[0] : 1'b0;
            e0   = mem_resp_v_i && have && !head;
            e1   = mem_resp_v_i && have && head;
            ey   = head ? (e1 && resp1_yumi_i) : (e0 && resp0_yumi_i);
            chk("mem_cmd_v", mem_cmd_v_o, ev);
            if (ev) chk("mem_cmd_data", mem_cmd_o, eg ? cmd1_i : cmd0_i);
            chk("cmd0_yumi", cmd0_yumi_o, hs && !eg);
            chk("cmd1_yumi", cmd1_yumi_o, hs && eg);
            chk("resp0_v", resp0_v_o, e0);
            chk("resp1_v", resp1_v_o, e1);
            chk("mem_resp_yumi", mem_resp_yumi_o, ey);
            chk("outstanding", outstanding_o, m_src.size());
            chk("idle", idle_o, !have && !ev);
            chk("error", error_o, m_err);
            if (resp0_v_o && resp0_yumi_i) begin
               r0_cnt++;
               if (exp0.size() == 0) begin
                  total++; bad++;
                  $display("FAIL resp0_unexpected: got %0h want none", resp0_o);
               end else chk("resp0_data", resp0_o, exp0.pop_front());
            end
            if (resp1_v_o && resp1_yumi_i) begin
               r1_cnt++;
               if (exp1.size() == 0) begin
                  total++; bad++;
                  $display("FAIL resp1_unexpected: got %0h want none", resp1_o);
               end else chk("resp1_data", resp1_o, exp1.pop_front());
            end
            if (int'(outstanding_o) > peak) peak = outstanding_o;
            if (cmd0_yumi_o) begin gseq.push_back(1'b0); hs_cnt++; end
            if (cmd1_yumi_o) begin gseq.push_back(1'b1); hs_cnt++; end
            if ((mem_resp_v_i && !have) || (resp0_yumi_i && !e0) || (resp1_yumi_i && !e1))
               m_err = 1;
            if (ey) void'(m_src.pop_front());
            if (hs) begin m_src.push_back(eg); m_prev = eg; end
         end
      end
   end

   task automatic do_reset();
      @(posedge clk_i);
      rst_req = 1;
      repeat (2) @(posedge clk_i);
      rst_req = 0;
      peak = 0; r0_cnt = 0; r1_cnt = 0; hs_cnt = 0; gseq.delete();
   endtask

   task automatic wait_idle(input int max_cyc);
      bit done;
      done = 0;
      for (int i = 0; i < max_cyc && !done; i++) begin
         @(negedge clk_i); #4;
         if (outstanding_o == 0 && c0_q.size() == 0 && c1_q.size() == 0 && mq_d.size() == 0)
            done = 1;
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL wait_idle_timeout: got outstanding=%0d want 0", outstanding_o);
      end
   endtask

   initial begin
      #800000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

   // Directed phases followed by a randomized soak.
   initial begin
      do_reset();
      @(negedge clk_i); #4;
      chk("reset_outstanding", outstanding_o, 0);
      chk("reset_idle", idle_o, 1);
      chk("reset_error", error_o, 0);

      // client 0 alone, memory answers 5 cycles later
      @(posedge clk_i);
      resp_delay = 5;
      repeat (3) push_cmd(0);
      wait_idle(100);
      chk("p1_peak", peak, 3);
      chk("p1_resp0_cnt", r0_cnt, 3);
      chk("p1_resp1_cnt", r1_cnt, 0);
      chk("p1_idle", idle_o, 1);

      // both clients continuously valid: strict alternation from client 0
      do_reset();
      resp_delay = 1;
      repeat (8) begin push_cmd(0); push_cmd(1); end
      wait_idle(200);
      chk("p2_grant_cnt", gseq.size(), 16);
      for (int i = 0; i < gseq.size() && i < 16; i++) chk("p2_alt_grant", gseq[i], i % 2);
      chk("p2_resp0_cnt", r0_cnt, 8);
      chk("p2_resp1_cnt", r1_cnt, 8);

      // responses withheld: tracker fills to 4, then one slot frees
      do_reset();
      hold_resp = 1;
      repeat (6) begin push_cmd(0); push_cmd(1); end
      repeat (10) @(posedge clk_i);
      @(negedge clk_i); #4;
      chk("p3_full_outstanding", outstanding_o, 4);
      chk("p3_full_hs", hs_cnt, 4);
      chk("p3_full_yumi", {cmd0_yumi_o, cmd1_yumi_o}, 0);
      @(posedge clk_i);
      release_cnt = 1;
      repeat (2) @(negedge clk_i);
      #4;
      chk("p3_after_pop", outstanding_o, 3);
      chk("p3_regrant_v", mem_cmd_v_o, 1);
      @(negedge clk_i); #4;
      chk("p3_refill", outstanding_o, 4);
      chk("p3_refill_hs", hs_cnt, 5);
      @(posedge clk_i);
      hold_resp = 0;
      wait_idle(300);

      // client 1 stalls its response yumi with head == 1
      do_reset();
      hold_resp = 1;
      repeat (2) push_cmd(1);
      repeat (4) @(posedge clk_i);
      repeat (2) push_cmd(0);
      repeat (4) @(posedge clk_i);
      hold_resp = 0;
      block_y1 = 1;
      repeat (10) @(posedge clk_i);
      @(negedge clk_i); #4;
      chk("p4_stall_outstanding", outstanding_o, 4);
      chk("p4_stall_resp1_v", resp1_v_o, 1);
      chk("p4_stall_yumi", mem_resp_yumi_o, 0);
      chk("p4_stall_resp0_cnt", r0_cnt, 0);
      @(posedge clk_i);
      block_y1 = 0;
      wait_idle(100);
      chk("p4_resp0_cnt", r0_cnt, 2);
      chk("p4_resp1_cnt", r1_cnt, 2);

      // drain with two outstanding
      do_reset();
      hold_resp = 1;
      repeat (2) push_cmd(0);
      repeat (4) @(posedge clk_i);
      drain_c = 1;
      repeat (2) push_cmd(1);
      repeat (3) @(posedge clk_i);
      @(negedge clk_i); #4;
      chk("p5_drain_hs", hs_cnt, 2);
      chk("p5_drain_mem_v", mem_cmd_v_o, 0);
      chk("p5_drain_outstanding", outstanding_o, 2);
      @(posedge clk_i);
      hold_resp = 0;
      for (int i = 0; i < 50 && outstanding_o != 0; i++) begin @(negedge clk_i); #4; end
      chk("p5_drained_outstanding", outstanding_o, 0);
      chk("p5_drained_idle", idle_o, 1);
      chk("p5_drained_hs", hs_cnt, 2);
      @(posedge clk_i);
      drain_c = 0;
      @(negedge clk_i); #4;
      chk("p5_resume_yumi", cmd1_yumi_o, 1);
      wait_idle(100);

      // unexpected response with an empty tracker
      @(posedge clk_i);
      spurious = 1;
      @(posedge clk_i);
      spurious = 0;
      @(negedge clk_i); #4;
      chk("p6_error_set", error_o, 1);
      repeat (3) @(negedge clk_i);
      #4;
      chk("p6_error_sticky", error_o, 1);
      chk("p6_no_resp_v", {resp0_v_o, resp1_v_o}, 0);
      do_reset();
      @(negedge clk_i); #4;
      chk("p6_error_cleared", error_o, 0);
      chk("p6_outstanding", outstanding_o, 0);
      chk("p6_idle", idle_o, 1);

      // random soak with a mid-run reset
      rand_ready = 1;
      rand_yumi  = 1;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk_i);
         if (c % 200 == 0) resp_delay = $urandom_range(6);
         drain_c = ($urandom_range(15) == 0);
         if ($urandom_range(2) == 0 && c0_q.size() < 6) push_cmd(0);
         if ($urandom_range(2) == 0 && c1_q.size() < 6) push_cmd(1);
         if (c == 1500) do_reset();
      end
      @(posedge clk_i);
      drain_c = 0;
      rand_ready = 0;
      rand_yumi = 0;
      wait_idle(500);
      chk("end_exp0_empty", exp0.size(), 0);
      chk("end_exp1_empty", exp1.size(), 0);
      chk("end_idle", idle_o, 1);
      chk("end_error", error_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
